// File: rtl/freq_scan_ctrl.sv
// freq_scan_ctrl: time-shares one frequency counter across NUM_CH clocks.
// Optional FREQ_SCAN_LIMIT_EN adds LO/HI limit compare and ALARM bits.
module freq_scan_ctrl #(
  parameter int NUM_CH         = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [2:0]  clk_sel,
  output logic        meas_start,
  input  logic        meas_done,
  input  logic [31:0] meas_count,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_START, S_WAIT, S_NEXT
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        ch_q, ch_d;
  logic [2:0]        sel_q, sel_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              start_q;
  logic [15:0]       pass_q, pass_d;
  logic              run_q, one_q, ien_q;
  logic [NUM_CH-1:0] mask_q, tmo_q, alarm;
  logic [NUM_CH-1:0] tmo_set, tmo_clr, ch_oh;
  logic [31:0]       res_q [NUM_CH];
  logic [31:0]       rd_d, rd_q;
  logic              res_we, one_clr;
  logic [31:0]       res_val;
  logic [3:0]        nx;
  logic              end_pass;

  function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] m);
    lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest = 3'(i);
  endfunction

  // {found, index} of the lowest enabled channel strictly above c
  function automatic logic [3:0] above(
    input logic [NUM_CH-1:0] m,
    input logic [2:0]        c
  );
    above = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i > int'(c)) above = {1'b1, 3'(i)};
  endfunction

  assign ch_oh    = NUM_CH'(1) << ch_q;
  assign nx       = above(mask_q, ch_q);
  assign end_pass = ~nx[3];

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    res_we  = 1'b0;
    res_val = '0;
    tmo_set = '0;
    one_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if ((run_q | one_q) && (|mask_q)) begin
          ch_d    = lowest(mask_q);
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        sel_d   = ch_q;
        cnt_d   = 32'(SETTLE_CYCLES);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_START;
        else             cnt_d   = cnt_q - 32'd1;
      end
      S_START: begin
        cnt_d   = 32'(TIMEOUT_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (meas_done) begin
          res_we  = 1'b1;
          res_val = meas_count;
          state_d = S_NEXT;
        end else if (cnt_q == '0) begin
          res_we  = 1'b1;
          tmo_set = ch_oh;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_NEXT: begin
        if (end_pass) pass_d = pass_q + 16'd1;
        one_clr = end_pass & one_q;
        if ((!run_q && !one_q) || one_clr || mask_q == '0) begin
          state_d = S_IDLE;
        end else begin
          ch_d    = end_pass ? lowest(mask_q) : nx[2:0];
          state_d = S_SELECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tmo_clr = (csr_write && csr_address == 4'd3)
                 ? csr_writedata[NUM_CH-1:0] : '0;

`ifdef FREQ_SCAN_LIMIT_EN
  logic [31:0]       lo_q, hi_q;
  logic [NUM_CH-1:0] alarm_q, al_clr, al_set;
  logic              hit;

  assign hit    = (meas_count < lo_q) | (meas_count > hi_q);
  assign al_set = (state_q == S_WAIT && meas_done && hit) ? ch_oh : '0;
  assign al_clr = (csr_write && csr_address == 4'd4)
                ? csr_writedata[NUM_CH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      alarm_q <= '0;
    end else begin
      if (csr_write && csr_address == 4'd5) lo_q <= csr_writedata;
      if (csr_write && csr_address == 4'd6) hi_q <= csr_writedata;
      alarm_q <= (alarm_q & ~al_clr) | al_set;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = '0;
`endif

  always_comb begin
    rd_d = '0;
    case (csr_address)
      4'd0: rd_d = {29'd0, ien_q, one_q, run_q};
      4'd1: rd_d = {pass_q, 5'd0, ch_q, 7'd0, state_q != S_IDLE};
      4'd2: rd_d = 32'(mask_q);
      4'd3: rd_d = 32'(tmo_q);
      4'd4: rd_d = 32'(alarm);
`ifdef FREQ_SCAN_LIMIT_EN
      4'd5: rd_d = lo_q;
      4'd6: rd_d = hi_q;
`endif
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++)
      if (csr_address == 4'(8 + i)) rd_d = res_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      pass_q  <= '0;
      run_q   <= 1'b0;
      one_q   <= 1'b0;
      ien_q   <= 1'b0;
      mask_q  <= '1;
      tmo_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      start_q <= (state_d == S_START);
      pass_q  <= pass_d;
      if (csr_read) rd_q <= rd_d;
      if (csr_write && csr_address == 4'd0) begin
        run_q <= csr_writedata[0];
        one_q <= csr_writedata[1];
        ien_q <= csr_writedata[2];
      end else if (one_clr) begin
        one_q <= 1'b0;
      end
      if (csr_write && csr_address == 4'd2)
        mask_q <= csr_writedata[NUM_CH-1:0];
      tmo_q <= (tmo_q & ~tmo_clr) | tmo_set;
      for (int i = 0; i < NUM_CH; i++)
        if (res_we && ch_q == 3'(i)) res_q[i] <= res_val;
    end
  end

  assign csr_readdata = rd_q;
  assign clk_sel      = sel_q;
  assign meas_start   = start_q;
  assign irq          = ien_q & ((|tmo_q) | (|alarm));

endmodule
